hook_ctrl: RTL and testbench

- Blitzcrank's hook launcher. It is the initiator side of the grab handshake consumed by the poro position block.
- On a fire request it extends the hook rightward from Blitzcrank, frame by frame, and tests for collision against the poro's x position.
- On a hit it raises `grab_success` for one clock (the poro then switches to grab velocity), then retracts and cools down.
- Sits between the keyboard/KEY input logic and the poro block; `hook_x` feeds the renderer.

---
 rtl/hook_ctrl.sv | 144 ++++++++++++++
 tb/tb_hook_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/hook_ctrl.sv
// Hook launcher: initiator side of the grab handshake with the poro block.
// On fire the tip extends rightward one step per frame and is tested for
// collision with the poro every clock. A hit pulses grab_success once, then
// the hook retracts to HOME_X and waits COOL_FRAMES frames before re-arming.
//
// Ports:
//   clk          system clock
//   resetn       synchronous active-low reset
//   frame        one-clk pulse per video frame
//   fire         launch request (level), sampled only in IDLE
//   hold         game hold/pause-reset; returns to IDLE, keeps hits
//   poro_x       current poro x position
//   grab_success one-clk hit pulse to the poro block
//   hook_x       current hook tip x (to renderer)
//   busy         high whenever state is not IDLE
//   state        IDLE=0, EXTEND=1, RETRACT=2, COOLDOWN=3
//   hits         saturating count of successful grabs
module hook_ctrl #(
    parameter logic [8:0] HOME_X      = 9'd43,
    parameter logic [8:0] MAX_X       = 9'd300,
    parameter logic [3:0] HOOK_V      = 4'd6,
    parameter logic [3:0] HIT_W       = 4'd8,
    parameter logic [5:0] COOL_FRAMES = 6'd30
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       frame,
    input  logic       fire,
    input  logic       hold,
    input  logic [8:0] poro_x,
    output logic       grab_success,
    output logic [8:0] hook_x,
    output logic       busy,
    output logic [1:0] state,
    output logic [7:0] hits
);

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StExtend   = 2'd1,
        StRetract  = 2'd2,
        StCooldown = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] hook_x_q, hook_x_d;
    logic       grab_q, grab_d;
    logic       busy_q;
    logic [7:0] hits_q, hits_d;
    logic [5:0] cool_q, cool_d;

    // 10-bit arithmetic so the window edge and the advance never wrap
    logic [9:0] win_hi;
    logic [9:0] adv;
    logic [9:0] ret_lim;
    logic [8:0] adv_clamped;
    logic       hit;

    assign win_hi      = {1'b0, hook_x_q} + {6'd0, HIT_W};
    assign adv         = {1'b0, hook_x_q} + {6'd0, HOOK_V};
    assign ret_lim     = {1'b0, HOME_X} + {6'd0, HOOK_V};
    assign adv_clamped = (adv > {1'b0, MAX_X}) ? MAX_X : adv[8:0];
    assign hit         = (poro_x >= hook_x_q) && ({1'b0, poro_x} <= win_hi);

    always_comb begin
        state_d  = state_q;
        hook_x_d = hook_x_q;
        grab_d   = 1'b0;
        hits_d   = hits_q;
        cool_d   = cool_q;

        if (hold) begin
            state_d  = StIdle;
            hook_x_d = HOME_X;
            cool_d   = 6'd0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    hook_x_d = HOME_X;
                    if (fire) state_d = StExtend;
                end
                StExtend: begin
                    // A hit freezes the tip and beats reaching MAX_X.
                    if (hit) begin
                        grab_d  = 1'b1;
                        hits_d  = (hits_q == 8'hFF) ? hits_q : hits_q + 8'd1;
                        state_d = StRetract;
                    end else if (hook_x_q == MAX_X) begin
                        state_d = StRetract;
                    end else if (frame) begin
                        hook_x_d = adv_clamped;
                    end
                end
                StRetract: begin
                    if (frame) begin
                        if ({1'b0, hook_x_q} <= ret_lim) begin
                            hook_x_d = HOME_X;
                            state_d  = StCooldown;
                            cool_d   = 6'd0;
                        end else begin
                            hook_x_d = hook_x_q - {5'd0, HOOK_V};
                        end
                    end
                end
                StCooldown: begin
                    if (frame) begin
                        if (cool_q == COOL_FRAMES - 6'd1) begin
                            state_d = StIdle;
                            cool_d  = 6'd0;
                        end else begin
                            cool_d = cool_q + 6'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= StIdle;
            hook_x_q <= HOME_X;
            grab_q   <= 1'b0;
            busy_q   <= 1'b0;
            hits_q   <= 8'd0;
            cool_q   <= 6'd0;
        end else begin
            state_q  <= state_d;
            hook_x_q <= hook_x_d;
            grab_q   <= grab_d;
            busy_q   <= (state_d != StIdle);
            hits_q   <= hits_d;
            cool_q   <= cool_d;
        end
    end

    assign grab_success = grab_q;
    assign hook_x       = hook_x_q;
    assign busy         = busy_q;
    assign state        = state_q;
    assign hits         = hits_q;

endmodule

// File: tb/tb_hook_ctrl.sv
module tb_hook_ctrl;

    logic       clk = 1'b0;
    logic       resetn, frame, fire, hold;
    logic [8:0] poro_x;
    logic       grab_success, busy;
    logic [8:0] hook_x;
    logic [1:0] state;
    logic [7:0] hits;

    int total = 0;
    int bad   = 0;
    bit check_en = 1'b0;

    // Reference model: plain integers, one update per clock from the rules.
    int m_st, m_tip, m_cnt, m_hits;
    bit m_gs;

    hook_ctrl dut (
        .clk         (clk),
        .resetn      (resetn),
        .frame       (frame),
        .fire        (fire),
        .hold        (hold),
        .poro_x      (poro_x),
        .grab_success(grab_success),
        .hook_x      (hook_x),
        .busy        (busy),
        .state       (state),
        .hits        (hits)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!resetn) begin
            m_st = 0; m_tip = 43; m_gs = 0; m_hits = 0; m_cnt = 0;
        end else if (hold) begin
            m_st = 0; m_tip = 43; m_gs = 0; m_cnt = 0;
        end else begin
            m_gs = 0;
            case (m_st)
                0: begin
                    m_tip = 43;
                    if (fire) m_st = 1;
                end
                1: begin
                    if (int'(poro_x) >= m_tip && int'(poro_x) <= m_tip + 8) begin
                        m_gs = 1;
                        m_hits = (m_hits + 1 > 255) ? 255 : m_hits + 1;
                        m_st = 2;
                    end else if (m_tip == 300) begin
                        m_st = 2;
                    end else if (frame) begin
                        m_tip = (m_tip + 6 > 300) ? 300 : m_tip + 6;
                    end
                end
                2: if (frame) begin
                    if (m_tip <= 49) begin
                        m_tip = 43; m_st = 3; m_cnt = 0;
                    end else begin
                        m_tip = m_tip - 6;
                    end
                end
                default: if (frame) begin
                    if (m_cnt == 29) begin
                        m_st = 0; m_cnt = 0;
                    end else begin
                        m_cnt = m_cnt + 1;
                    end
                end
            endcase
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            check("model_state", int'(state), m_st);
            check("model_hook_x", int'(hook_x), m_tip);
            check("model_busy", int'(busy), int'(m_st != 0));
            check("model_grab", int'(grab_success), int'(m_gs));
            check("model_hits", int'(hits), m_hits);
        end
    end

    // Apply frame for one clock; return at the next negedge with outputs updated.
    task automatic step(input bit f);
        frame = f;
        @(negedge clk);
        frame = 1'b0;
    endtask

    task automatic go_idle();
        hold = 1'b1;
        step(1'b0);
        hold = 1'b0;
    endtask

    initial begin
        int n, pulses, seen_tip, max_tip;
        bit done;
        resetn = 1'b0; frame = 1'b0; fire = 1'b1; hold = 1'b0; poro_x = 9'd80;
        @(negedge clk);
        @(negedge clk);
        check("reset_hook_x", int'(hook_x), 43);
        check("reset_state", int'(state), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_hits", int'(hits), 0);
        check("reset_grab", int'(grab_success), 0);
        fire = 1'b0;
        resetn = 1'b1;
        check_en = 1'b1;

        // Hit at tip 73 with poro at 80
        fire = 1'b1; step(1'b0); fire = 1'b0;
        check("hit_extend_entry", int'(state), 1);
        done = 0; seen_tip = -1; pulses = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            step(i % 2 == 0);
            if (grab_success) begin
                done = 1; seen_tip = int'(hook_x);
            end
        end
        check("hit_pulse_seen", int'(done), 1);
        check("hit_tip", seen_tip, 73);
        check("hit_count", int'(hits), 1);
        step(1'b0);
        check("hit_pulse_width", int'(grab_success), 0);
        check("hit_retract", int'(state), 2);
        n = 0;
        while (state == 2'd2 && n < 20) begin
            fire = 1'b1; step(1'b0); fire = 1'b0;
            check("fire_ign_retract", int'(state), 2);
            step(1'b1); n++;
        end
        check("retract_frames", n, 5);
        check("retract_home", int'(hook_x), 43);
        n = 0;
        while (state == 2'd3 && n < 40) begin
            fire = 1'b1; step(1'b0); fire = 1'b0;
            check("fire_ign_cool", int'(state), 3);
            step(1'b1); n++;
        end
        check("cool_frames", n, 30);
        check("cool_idle", int'(state), 0);

        // Miss: tip clamps at 300, no pulse
        poro_x = 9'd319;
        fire = 1'b1; step(1'b0); fire = 1'b0;
        n = 0; max_tip = 0; pulses = 0;
        while (state == 2'd1 && n < 200) begin
            step(1'b1); n++;
            if (int'(hook_x) > max_tip) max_tip = int'(hook_x);
            if (grab_success) pulses++;
        end
        check("miss_retract", int'(state), 2);
        check("miss_max_tip", max_tip, 300);
        check("miss_pulses", pulses, 0);
        check("miss_hits", int'(hits), 1);

        // Drain, then hold fire through the end of cooldown
        n = 0;
        while (state != 2'd0 && n < 200) begin
            fire = (state == 2'd3);
            step(1'b1); n++;
        end
        check("relaunch_idle", int'(state), 0);
        step(1'b0);
        check("relaunch_extend", int'(state), 1);
        fire = 1'b0;

        // Hold mid-extend at tip 97
        n = 0;
        while (hook_x != 9'd97 && n < 100) begin
            step(1'b1); n++;
        end
        check("hold_tip_reached", int'(hook_x), 97);
        hold = 1'b1; step(1'b1); hold = 1'b0;
        check("hold_state", int'(state), 0);
        check("hold_hook_x", int'(hook_x), 43);
        check("hold_hits", int'(hits), 1);
        check("hold_grab", int'(grab_success), 0);

        // Hit and MAX_X on the same clock: poro 304 first hits at tip 300
        poro_x = 9'd304;
        fire = 1'b1; step(1'b0); fire = 1'b0;
        n = 0; seen_tip = -1;
        while (state == 2'd1 && n < 200) begin
            step(1'b1); n++;
            if (grab_success) seen_tip = int'(hook_x);
        end
        check("edge_tip", seen_tip, 300);
        check("edge_hits", int'(hits), 2);
        step(1'b1);
        check("edge_no_extend", int'(hook_x), 294);
        go_idle();

        // Saturation: enough immediate hits to pass 255
        poro_x = 9'd43; fire = 1'b1; pulses = 0; n = 0;
        while (pulses < 256 && n < 20000) begin
            step(1'b1); n++;
            if (grab_success) pulses++;
        end
        fire = 1'b0;
        check("sat_pulses", pulses, 256);
        check("sat_hits", int'(hits), 255);
        go_idle();
        check("sat_hold_hits", int'(hits), 255);

        check_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
